// File: rtl/data_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_arbiter
// Brief    : Shares the single-port data RAM between the CPU data port and a
//            host port; the host steals idle cycles or forces a bounded stall.
// Revision : 1.0
// ============================================================================
module data_ram_arbiter #(
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clock_enable,
    output logic        cpu_clock_enable,
    input  logic [31:0] cpu_data_address,
    input  logic        cpu_data_read,
    input  logic        cpu_data_write,
    input  logic [31:0] cpu_data_writedata,
    output logic [31:0] cpu_data_readdata,
    input  logic        host_req,
    input  logic        host_write,
    input  logic [31:0] host_address,
    input  logic [31:0] host_writedata,
    output logic        host_ack,
    output logic [31:0] host_readdata,
    output logic        host_owns,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_data_in,
    output logic        ram_data_read,
    output logic        ram_data_write,
    input  logic [31:0] ram_data_out
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [WW-1:0] c_WAIT_LAST  = WW'(MAX_WAIT - 1);
    localparam logic [WW-1:0] c_WAIT_SAT   = WW'(MAX_WAIT);
    localparam logic [BW-1:0] c_BURST_LAST = BW'(BURST_MAX - 1);

    typedef enum logic [0:0] {
        S_CPU_OWN = 1'b0,
        S_HOST    = 1'b1
    } state_t;

    state_t        r_state;
    logic [WW-1:0] r_wait_cnt;
    logic [BW-1:0] r_burst_cnt;

    logic w_cpu_busy;
    logic w_host_drive;

    always_comb begin
        w_cpu_busy   = clock_enable & (cpu_data_read | cpu_data_write);
        // Select depends only on state, host_req and cpu_busy.
        w_host_drive = (r_state == S_HOST) | (host_req & ~w_cpu_busy);

        ram_addr     = w_host_drive ? host_address   : cpu_data_address;
        ram_data_in  = w_host_drive ? host_writedata : cpu_data_writedata;

        ram_data_read  = 1'b0;
        ram_data_write = 1'b0;
        host_ack       = 1'b0;
        if (reset) begin
            ram_data_read  = 1'b0;
            ram_data_write = 1'b0;
        end else if (w_host_drive) begin
            // A HOST-state cycle without a request is a dead cycle.
            host_ack       = host_req;
            ram_data_read  = host_req & ~host_write;
            ram_data_write = host_req &  host_write;
        end else begin
            ram_data_read  = clock_enable & cpu_data_read;
            ram_data_write = clock_enable & cpu_data_write;
        end

        cpu_clock_enable = (reset || r_state == S_CPU_OWN) ? clock_enable : 1'b0;
        host_owns        = ~reset & (r_state == S_HOST);
    end

    assign cpu_data_readdata = ram_data_out;
    assign host_readdata     = ram_data_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_CPU_OWN;
            r_wait_cnt  <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                S_CPU_OWN: begin
                    if (!host_req || !w_cpu_busy) begin
                        r_wait_cnt <= '0;
                    end else begin
                        if (r_wait_cnt != c_WAIT_SAT)
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        if (r_wait_cnt == c_WAIT_LAST) begin
                            r_state     <= S_HOST;
                            r_burst_cnt <= '0;
                        end
                    end
                end
                S_HOST: begin
                    if (host_req && r_burst_cnt != c_BURST_LAST) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end else begin
                        // Burst exhausted or host went away: return the RAM.
                        r_state     <= S_CPU_OWN;
                        r_wait_cnt  <= '0;
                        r_burst_cnt <= '0;
                    end
                end
                default: begin
                    r_state     <= S_CPU_OWN;
                    r_wait_cnt  <= '0;
                    r_burst_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_ram_arbiter
// Brief    : Directed self-checking bench for data_ram_arbiter with a RAM model.
// Revision : 1.0
// ============================================================================
module tb_data_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clock_enable = 1'b1;
    logic        cpu_clock_enable;
    logic [31:0] cpu_data_address = '0;
    logic        cpu_data_read = 1'b0;
    logic        cpu_data_write = 1'b0;
    logic [31:0] cpu_data_writedata = '0;
    logic [31:0] cpu_data_readdata;
    logic        host_req = 1'b0;
    logic        host_write = 1'b0;
    logic [31:0] host_address = '0;
    logic [31:0] host_writedata = '0;
    logic        host_ack;
    logic [31:0] host_readdata;
    logic        host_owns;
    logic [31:0] ram_addr;
    logic [31:0] ram_data_in;
    logic        ram_data_read;
    logic        ram_data_write;
    logic [31:0] ram_data_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:255];

    data_ram_arbiter #(.MAX_WAIT(4), .BURST_MAX(4)) dut (
        .clk(clk), .reset(reset), .clock_enable(clock_enable),
        .cpu_clock_enable(cpu_clock_enable),
        .cpu_data_address(cpu_data_address), .cpu_data_read(cpu_data_read),
        .cpu_data_write(cpu_data_write), .cpu_data_writedata(cpu_data_writedata),
        .cpu_data_readdata(cpu_data_readdata),
        .host_req(host_req), .host_write(host_write), .host_address(host_address),
        .host_writedata(host_writedata), .host_ack(host_ack),
        .host_readdata(host_readdata), .host_owns(host_owns),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_data_read(ram_data_read), .ram_data_write(ram_data_write),
        .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Word-addressed RAM model: combinational read, write at posedge.
    assign ram_data_out = mem[ram_addr[9:2]];
    always @(posedge clk) if (ram_data_write) mem[ram_addr[9:2]] <= ram_data_in;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clock_enable = 1'b1;
        host_req = 1'b1; host_write = 1'b1; host_address = 32'h20; host_writedata = 32'h0BAD0BAD;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (host_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack[%0d]: got %b expected 0", i, host_ack); end
            n_checks++; if (ram_data_write !== 1'b0) begin n_fail++; $display("FAIL reset_ram_write[%0d]: got %b expected 0", i, ram_data_write); end
            n_checks++; if (host_owns !== 1'b0) begin n_fail++; $display("FAIL reset_owns[%0d]: got %b expected 0", i, host_owns); end
            n_checks++; if (cpu_clock_enable !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_ce[%0d]: got %b expected 1", i, cpu_clock_enable); end
            step();
        end
        reset = 1'b0; host_req = 1'b0; host_write = 1'b0;
        step();
    endtask

    task automatic test_idle_steal();
        host_req = 1'b1; host_write = 1'b1; host_address = 32'h10; host_writedata = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++; if (host_ack !== 1'b1) begin n_fail++; $display("FAIL steal_ack: got %b expected 1", host_ack); end
        n_checks++; if (cpu_clock_enable !== 1'b1) begin n_fail++; $display("FAIL steal_cpu_ce: got %b expected 1", cpu_clock_enable); end
        n_checks++; if (ram_data_write !== 1'b1 || ram_addr !== 32'h10) begin n_fail++; $display("FAIL steal_ram_port: got we=%b addr=%h expected we=1 addr=00000010", ram_data_write, ram_addr); end
        step();
        host_address = 32'h20; host_writedata = 32'h11112222;
        @(negedge clk);
        n_checks++; if (host_ack !== 1'b1) begin n_fail++; $display("FAIL steal2_ack: got %b expected 1", host_ack); end
        step();
        host_req = 1'b0; host_write = 1'b0;
        cpu_data_read = 1'b1; cpu_data_address = 32'h10;
        @(negedge clk);
        n_checks++; if (cpu_data_readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cpu_readback: got %h expected deadbeef", cpu_data_readdata); end
        n_checks++; if (ram_data_read !== 1'b1 || host_ack !== 1'b0) begin n_fail++; $display("FAIL cpu_read_port: got rd=%b ack=%b expected rd=1 ack=0", ram_data_read, host_ack); end
        step();
        cpu_data_read = 1'b0;
        step();
    endtask

    // Busy CPU: 4 blocked cycles, 4 forced acks, repeated.
    task automatic test_forced_grant();
        logic exp_ack;
        cpu_data_read = 1'b1; cpu_data_address = 32'h10;
        host_req = 1'b1; host_write = 1'b0; host_address = 32'h10;
        for (int i = 0; i < 16; i++) begin
            exp_ack = ((i / 4) % 2) == 1;
            @(negedge clk);
            n_checks++; if (host_ack !== exp_ack) begin n_fail++; $display("FAIL grant_ack[%0d]: got %b expected %b", i, host_ack, exp_ack); end
            n_checks++; if (host_owns !== exp_ack) begin n_fail++; $display("FAIL grant_owns[%0d]: got %b expected %b", i, host_owns, exp_ack); end
            n_checks++; if (cpu_clock_enable !== !exp_ack) begin n_fail++; $display("FAIL grant_cpu_ce[%0d]: got %b expected %b", i, cpu_clock_enable, !exp_ack); end
            if (exp_ack) begin
                n_checks++; if (host_readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL grant_rdata[%0d]: got %h expected deadbeef", i, host_readdata); end
            end
            step();
        end
        host_req = 1'b0; cpu_data_read = 1'b0;
        step();
    endtask

    task automatic test_dead_cycle();
        cpu_data_read = 1'b1; cpu_data_address = 32'h10;
        host_req = 1'b1; host_write = 1'b0; host_address = 32'h20;
        repeat (4) step();
        @(negedge clk);
        n_checks++; if (host_owns !== 1'b1 || host_ack !== 1'b1) begin n_fail++; $display("FAIL dead_entry: got owns=%b ack=%b expected 1 1", host_owns, host_ack); end
        step();
        host_req = 1'b0;
        @(negedge clk);
        n_checks++; if (host_owns !== 1'b1 || cpu_clock_enable !== 1'b0) begin n_fail++; $display("FAIL dead_state: got owns=%b ce=%b expected 1 0", host_owns, cpu_clock_enable); end
        n_checks++; if (host_ack !== 1'b0 || ram_data_read !== 1'b0 || ram_data_write !== 1'b0) begin n_fail++; $display("FAIL dead_strobes: got ack=%b rd=%b we=%b expected 0 0 0", host_ack, ram_data_read, ram_data_write); end
        step();
        @(negedge clk);
        n_checks++; if (host_owns !== 1'b0 || cpu_clock_enable !== 1'b1 || ram_data_read !== 1'b1) begin n_fail++; $display("FAIL dead_return: got owns=%b ce=%b rd=%b expected 0 1 1", host_owns, cpu_clock_enable, ram_data_read); end
        step();
        cpu_data_read = 1'b0;
        step();
    endtask

    task automatic test_reset_in_host();
        cpu_data_read = 1'b1; cpu_data_address = 32'h10;
        host_req = 1'b1; host_write = 1'b1; host_address = 32'h20; host_writedata = 32'h0BADBAD0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (host_ack !== 1'b0 || ram_data_write !== 1'b0) begin n_fail++; $display("FAIL rsthost_wait[%0d]: got ack=%b we=%b expected 0 0", i, host_ack, ram_data_write); end
            step();
        end
        @(negedge clk);
        n_checks++; if (host_owns !== 1'b1) begin n_fail++; $display("FAIL rsthost_owns_pre: got %b expected 1", host_owns); end
        reset = 1'b1;
        #1;
        n_checks++; if (host_ack !== 1'b0 || ram_data_write !== 1'b0) begin n_fail++; $display("FAIL rsthost_strobes: got ack=%b we=%b expected 0 0", host_ack, ram_data_write); end
        n_checks++; if (host_owns !== 1'b0 || cpu_clock_enable !== 1'b1) begin n_fail++; $display("FAIL rsthost_status: got owns=%b ce=%b expected 0 1", host_owns, cpu_clock_enable); end
        step();
        reset = 1'b0; host_req = 1'b0; host_write = 1'b0; cpu_data_read = 1'b0;
        @(negedge clk);
        n_checks++; if (host_owns !== 1'b0 || cpu_clock_enable !== 1'b1) begin n_fail++; $display("FAIL rsthost_after: got owns=%b ce=%b expected 0 1", host_owns, cpu_clock_enable); end
        step();
        host_req = 1'b1;
        @(negedge clk);
        n_checks++; if (host_ack !== 1'b1 || host_readdata !== 32'h11112222) begin n_fail++; $display("FAIL rsthost_mem: got ack=%b data=%h expected 1 11112222", host_ack, host_readdata); end
        step();
        host_req = 1'b0;
        step();
    endtask

    task automatic test_frozen_cpu();
        clock_enable = 1'b0;
        cpu_data_write = 1'b1; cpu_data_address = 32'h10; cpu_data_writedata = 32'h0;
        @(negedge clk);
        n_checks++; if (ram_data_write !== 1'b0 || cpu_clock_enable !== 1'b0) begin n_fail++; $display("FAIL frozen_write: got we=%b ce=%b expected 0 0", ram_data_write, cpu_clock_enable); end
        step();
        host_req = 1'b1; host_write = 1'b0; host_address = 32'h10;
        @(negedge clk);
        n_checks++; if (host_ack !== 1'b1 || host_readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL frozen_host_read: got ack=%b data=%h expected 1 deadbeef", host_ack, host_readdata); end
        n_checks++; if (ram_data_write !== 1'b0 || ram_data_read !== 1'b1) begin n_fail++; $display("FAIL frozen_host_strobes: got we=%b rd=%b expected 0 1", ram_data_write, ram_data_read); end
        step();
        host_req = 1'b0; cpu_data_write = 1'b0; clock_enable = 1'b1;
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_idle_steal();
        test_forced_grant();
        test_dead_cycle();
        test_reset_in_host();
        test_frozen_cpu();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
